// File: rtl/alu_op_scheduler_pkg.sv
// Shared definitions for the ALU operation scheduler: opcode encodings,
// register-write encodings and the captured-request record.
package alu_op_scheduler_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOT  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_MOV  = 5'd8;
    localparam logic [4:0] OP_INC  = 5'd9;
    localparam logic [4:0] OP_DEC  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;
    localparam logic [4:0] OP_CMP  = 5'd13;
    localparam logic [4:0] OP_SETF = 5'd14;
    localparam logic [4:0] OP_CLRF = 5'd15;
    localparam logic [4:0] OP_CPLF = 5'd16;
    // Encodings above this value are undefined.
    localparam logic [4:0] OP_LAST = OP_CPLF;

    localparam logic [1:0] RESP_WR_NONE = 2'b00;
    localparam logic [1:0] RESP_WR_R0   = 2'b01;
    localparam logic [1:0] RESP_WR_R0R1 = 2'b11;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [3:0]  bitpos;
    } alu_req_t;

    function automatic logic is_muldiv(input logic [4:0] opc);
        return (opc == OP_MUL) || (opc == OP_DIV);
    endfunction

    // Divide by zero only produces the saturated quotient in result_0.
    function automatic logic [1:0] resp_wr_en_f(input logic [4:0] opc, input logic [15:0] op2);
        logic [1:0] wr;
        case (opc)
            OP_MUL:                            wr = RESP_WR_R0R1;
            OP_DIV:                            wr = (op2 == 16'h0000) ? RESP_WR_R0 : RESP_WR_R0R1;
            OP_CMP, OP_SETF, OP_CLRF, OP_CPLF: wr = RESP_WR_NONE;
            default:                           wr = (opc <= OP_LAST) ? RESP_WR_R0 : RESP_WR_NONE;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester at or above rr_ptr_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               grant_vld_o
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        grant_o     = '0;
        grant_id_o  = '0;
        grant_vld_o = 1'b0;
        idx         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (req_valid_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_id_o   = idx;
                grant_vld_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one combinational ALU between NUM_REQ requesters; owns the
// architectural flag register and returns tagged responses.
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = 1,
    parameter int MULDIV_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*5-1:0]  req_opcode,
    input  logic [NUM_REQ*16-1:0] req_op1,
    input  logic [NUM_REQ*16-1:0] req_op2,
    input  logic [NUM_REQ*4-1:0]  req_bitpos,
    output logic [4:0]            alu_opcode,
    output logic [15:0]           alu_operand_1,
    output logic [15:0]           alu_operand_2,
    output logic [3:0]            alu_bit_position,
    output logic [15:0]           alu_current_flags,
    input  logic [15:0]           alu_result_0,
    input  logic [15:0]           alu_result_1,
    input  logic [15:0]           alu_next_flags,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_result_0,
    output logic [15:0]           resp_result_1,
    output logic [1:0]            resp_wr_en,
    output logic [15:0]           flags,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    logic [NUM_REQ-1:0][4:0]  opc_a;
    logic [NUM_REQ-1:0][15:0] op1_a;
    logic [NUM_REQ-1:0][15:0] op2_a;
    logic [NUM_REQ-1:0][3:0]  bp_a;

    assign opc_a = req_opcode;
    assign op1_a = req_op1;
    assign op2_a = req_op2;
    assign bp_a  = req_bitpos;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0]      flags_q, flags_d;
    alu_req_t         op_q, op_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      res0_q, res0_d;
    logic [15:0]      res1_q, res1_d;
    logic [1:0]       wr_en_q, wr_en_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;
    logic               in_idle;
    logic               in_exec;
    logic               handshake;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_id_o  (grant_id),
        .grant_vld_o (grant_vld)
    );

    assign in_idle   = (state_q == S_IDLE);
    assign in_exec   = (state_q == S_EXEC);
    // A flush in IDLE suppresses the grant for that cycle.
    assign req_ready = (in_idle && !flush) ? grant : '0;
    assign handshake = in_idle && !flush && grant_vld;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        flags_d  = flags_q;
        op_d     = op_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        res0_d   = res0_q;
        res1_d   = res1_q;
        wr_en_d  = wr_en_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    op_d.opcode = opc_a[grant_id];
                    op_d.op1    = op1_a[grant_id];
                    op_d.op2    = op2_a[grant_id];
                    op_d.bitpos = bp_a[grant_id];
                    id_d        = grant_id;
                    rr_ptr_d    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
                    cnt_d       = is_muldiv(opc_a[grant_id]) ? CNT_W'(MULDIV_LAT - 1) : '0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res0_d  = alu_result_0;
                    res1_d  = alu_result_1;
                    flags_d = alu_next_flags;
                    wr_en_d = resp_wr_en_f(op_q.opcode, op_q.op2);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            flags_q  <= '0;
            op_q     <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            wr_en_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            wr_en_q  <= wr_en_d;
        end
    end

    assign alu_opcode        = in_exec ? op_q.opcode : '0;
    assign alu_operand_1     = in_exec ? op_q.op1    : '0;
    assign alu_operand_2     = in_exec ? op_q.op2    : '0;
    assign alu_bit_position  = in_exec ? op_q.bitpos : '0;
    assign alu_current_flags = flags_q;

    assign resp_valid    = (state_q == S_RESP);
    assign resp_id       = id_q;
    assign resp_result_0 = res0_q;
    assign resp_result_1 = res1_q;
    assign resp_wr_en    = wr_en_q;
    assign flags         = flags_q;
    assign busy          = !in_idle;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Randomized bench for alu_op_scheduler: drives an ALU model, predicts each
// transaction (grant, latency, results, write enables, flags) from the rules.
module tb_alu_op_scheduler;
    import alu_op_scheduler_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int LAT     = 3;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  flush;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*5-1:0]  req_opcode;
    logic [NUM_REQ*16-1:0] req_op1;
    logic [NUM_REQ*16-1:0] req_op2;
    logic [NUM_REQ*4-1:0]  req_bitpos;
    logic [4:0]            alu_opcode;
    logic [15:0]           alu_operand_1, alu_operand_2;
    logic [3:0]            alu_bit_position;
    logic [15:0]           alu_current_flags;
    logic [15:0]           alu_result_0, alu_result_1, alu_next_flags;
    logic                  resp_valid, resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_result_0, resp_result_1;
    logic [1:0]            resp_wr_en;
    logic [15:0]           flags;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2), .req_bitpos(req_bitpos),
        .alu_opcode(alu_opcode), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_bit_position(alu_bit_position), .alu_current_flags(alu_current_flags),
        .alu_result_0(alu_result_0), .alu_result_1(alu_result_1), .alu_next_flags(alu_next_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result_0(resp_result_0), .resp_result_1(resp_result_1), .resp_wr_en(resp_wr_en),
        .flags(flags), .busy(busy)
    );

    typedef struct packed {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] nf;
    } alu_out_t;

    // Flag bits: C=0 V=1 N=2 Z=3 P=4 (P set on even parity).
    function automatic alu_out_t alu_f(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] bp, input logic [15:0] f);
        alu_out_t o;
        logic [16:0] s;
        logic [31:0] p;
        logic c, v, arith;
        o = '0; o.nf = f; c = 1'b0; v = 1'b0; arith = 1'b1; s = '0; p = '0;
        case (opc)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; o.r0 = s[15:0]; c = s[16];
                          v = (a[15] == b[15]) && (o.r0[15] != a[15]); end
            OP_SUB, OP_CMP: begin s = {1'b0, a} - {1'b0, b}; o.r0 = s[15:0]; c = s[16];
                          v = (a[15] != b[15]) && (o.r0[15] != a[15]); end
            OP_AND: o.r0 = a & b;
            OP_OR:  o.r0 = a | b;
            OP_XOR: o.r0 = a ^ b;
            OP_NOT: o.r0 = ~a;
            OP_SHL: o.r0 = a << bp;
            OP_SHR: o.r0 = a >> bp;
            OP_MOV: o.r0 = b;
            OP_INC: o.r0 = a + 16'd1;
            OP_DEC: o.r0 = a - 16'd1;
            OP_MUL: begin p = a * b; o.r0 = p[15:0]; o.r1 = p[31:16]; end
            OP_DIV: begin
                if (b == 16'h0) begin o.r0 = 16'hFFFF; v = 1'b1; end
                else begin o.r0 = a / b; o.r1 = a % b; end
            end
            OP_SETF: begin arith = 1'b0; o.nf = f | (16'd1 << bp); end
            OP_CLRF: begin arith = 1'b0; o.nf = f & ~(16'd1 << bp); end
            OP_CPLF: begin arith = 1'b0; o.nf = f ^ (16'd1 << bp); end
            default: begin arith = 1'b0; o.r0 = a; o.r1 = b; o.nf = {a[15:8], f[7:0]}; end
        endcase
        if (arith) begin
            o.nf[0] = c; o.nf[1] = v; o.nf[2] = o.r0[15];
            o.nf[3] = (o.r0 == 16'h0); o.nf[4] = ~^o.r0;
        end
        return o;
    endfunction

    function automatic logic [1:0] exp_wr(input logic [4:0] opc, input logic [15:0] b);
        if (opc > OP_CPLF) return 2'b00;
        if (opc == OP_CMP || opc == OP_SETF || opc == OP_CLRF || opc == OP_CPLF) return 2'b00;
        if (opc == OP_MUL) return 2'b11;
        if (opc == OP_DIV) return (b == 16'h0) ? 2'b01 : 2'b11;
        return 2'b01;
    endfunction

    alu_out_t ao;
    always_comb ao = alu_f(alu_opcode, alu_operand_1, alu_operand_2, alu_bit_position, alu_current_flags);
    assign alu_result_0   = ao.r0;
    assign alu_result_1   = ao.r1;
    assign alu_next_flags = ao.nf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Requester slots and the transaction-level model state.
    logic [NUM_REQ-1:0][4:0]  s_opc;
    logic [NUM_REQ-1:0][15:0] s_op1, s_op2;
    logic [NUM_REQ-1:0][3:0]  s_bp;
    logic [15:0] m_flags;
    int          m_rr;

    task automatic set_slot(input int i, input logic [4:0] opc, input logic [15:0] a,
                            input logic [15:0] b, input logic [3:0] bp);
        s_opc[i] = opc; s_op1[i] = a; s_op2[i] = b; s_bp[i] = bp;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] vmask);
        req_opcode = s_opc; req_op1 = s_op1; req_op2 = s_op2; req_bitpos = s_bp;
        req_valid  = vmask;
    endtask

    // Called at a negedge with the DUT idle. fmode: 0 normal, 1 flush in EXEC,
    // 2 flush in RESP. Cycle numbering: request cycle 0, response in cycle 1+lat.
    task automatic do_op(input logic [NUM_REQ-1:0] vmask, input int stall, input int fmode,
                         output logic [15:0] o_r0, output logic [15:0] o_r1, output logic [1:0] o_wr);
        int g, n, elat;
        logic [NUM_REQ-1:0] oh;
        alu_out_t e;
        logic [4:0] eopc;
        logic [15:0] sr0, sr1;
        logic [1:0] swr;
        g = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (vmask[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
        oh = '0; oh[g] = 1'b1;
        eopc = s_opc[g];
        e    = alu_f(eopc, s_op1[g], s_op2[g], s_bp[g], m_flags);
        elat = (eopc == OP_MUL || eopc == OP_DIV) ? LAT : 1;
        o_r0 = '0; o_r1 = '0; o_wr = '0;
        drive(vmask);
        #1 chk("req_ready", 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = '0;
        m_rr = (g + 1) % NUM_REQ;
        chk("exec_busy", 32'(busy), 1);
        chk("alu_opc", 32'(alu_opcode), 32'(eopc));
        chk("alu_op1", 32'(alu_operand_1), 32'(s_op1[g]));
        chk("alu_op2", 32'(alu_operand_2), 32'(s_op2[g]));
        chk("alu_bp", 32'(alu_bit_position), 32'(s_bp[g]));
        chk("alu_flags_in", 32'(alu_current_flags), 32'(m_flags));
        if (fmode == 1) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("flush_exec_busy", 32'(busy), 0);
            chk("flush_exec_rv", 32'(resp_valid), 0);
            chk("flush_exec_flags", 32'(flags), 32'(m_flags));
            return;
        end
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, elat);
        chk("resp_id", 32'(resp_id), g);
        chk("resp_r0", 32'(resp_result_0), 32'(e.r0));
        chk("resp_r1", 32'(resp_result_1), 32'(e.r1));
        chk("resp_wr", 32'(resp_wr_en), 32'(exp_wr(eopc, s_op2[g])));
        chk("flags_commit", 32'(flags), 32'(e.nf));
        chk("alu_idle_resp", 32'(alu_opcode), 0);
        m_flags = e.nf;
        o_r0 = resp_result_0; o_r1 = resp_result_1; o_wr = resp_wr_en;
        if (fmode == 2) begin
            flush = 1'b1; resp_ready = 1'b1;
            @(negedge clk);
            flush = 1'b0; resp_ready = 1'b0;
            chk("flush_resp_rv", 32'(resp_valid), 0);
            chk("flush_resp_flags", 32'(flags), 32'(m_flags));
            return;
        end
        sr0 = resp_result_0; sr1 = resp_result_1; swr = resp_wr_en;
        for (int s = 0; s < stall; s++) begin
            req_valid = vmask;
            #1 chk("stall_no_grant", 32'(req_ready), 0);
            @(negedge clk);
            chk("stall_rv", 32'(resp_valid), 1);
            chk("stall_stable", {sr0, sr1}, {resp_result_0, resp_result_1});
            chk("stall_wr", 32'(resp_wr_en), 32'(swr));
        end
        req_valid = '0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("done_rv", 32'(resp_valid), 0);
        chk("done_busy", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r0, r1;
        logic [1:0]  wr;
        reset_n = 1'b0; flush = 1'b0; resp_ready = 1'b0; req_valid = '0;
        s_opc = '0; s_op1 = '0; s_op2 = '0; s_bp = '0;
        drive('0);
        m_flags = '0; m_rr = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv", 32'(resp_valid), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_wr", 32'(resp_wr_en), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_res", {resp_result_0, resp_result_1}, 0);
        chk("rst_alu", {alu_opcode, alu_operand_1}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        set_slot(0, OP_ADD, 16'h7FFF, 16'h0001, 4'd0);
        do_op(2'b01, 0, 0, r0, r1, wr);
        chk("add_r0", 32'(r0), 32'h8000);
        chk("add_wr", 32'(wr), 32'h1);
        chk("add_flags", 32'(flags), 32'h0006);

        // Both requesters valid: grants alternate (model checks order).
        set_slot(0, OP_INC, 16'h0010, 16'h0, 4'd0);
        set_slot(1, OP_XOR, 16'h00FF, 16'h0F0F, 4'd0);
        for (int i = 0; i < 4; i++) do_op(2'b11, 0, 0, r0, r1, wr);

        set_slot(0, OP_MUL, 16'h1234, 16'h0100, 4'd0);
        do_op(2'b01, 0, 0, r0, r1, wr);
        chk("mul_r1", 32'(r1), 32'h0012);
        chk("mul_r0", 32'(r0), 32'h3400);
        chk("mul_wr", 32'(wr), 32'h3);

        set_slot(1, OP_DIV, 16'h0010, 16'h0000, 4'd0);
        do_op(2'b10, 0, 0, r0, r1, wr);
        chk("div0_r0", 32'(r0), 32'hFFFF);
        chk("div0_wr", 32'(wr), 32'h1);
        chk("div0_v", 32'(flags[1]), 1);
        set_slot(0, OP_SETF, 16'h0, 16'h0, 4'd4);
        do_op(2'b01, 0, 0, r0, r1, wr);
        chk("setf_wr", 32'(wr), 0);
        chk("setf_bit4", 32'(flags[4]), 1);
        chk("setf_bit1", 32'(flags[1]), 1);

        set_slot(1, OP_SUB, 16'h0003, 16'h0005, 4'd0);
        do_op(2'b10, 5, 0, r0, r1, wr);
        set_slot(0, OP_MUL, 16'h00FF, 16'h00FF, 4'd0);
        do_op(2'b01, 0, 1, r0, r1, wr);

        // Flush in IDLE suppresses the grant and leaves the pointer alone.
        drive(2'b01); flush = 1'b1;
        #1 chk("flush_idle_ready", 32'(req_ready), 0);
        @(negedge clk);
        flush = 1'b0; req_valid = '0;
        chk("flush_idle_busy", 32'(busy), 0);

        // Asynchronous reset mid-EXEC.
        set_slot(0, OP_SETF, 16'h0, 16'h0, 4'd9);
        do_op(2'b01, 0, 0, r0, r1, wr);
        set_slot(0, OP_MUL, 16'h0002, 16'h0003, 4'd0);
        drive(2'b01);
        @(negedge clk);
        req_valid = '0;
        chk("pre_rst_busy", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_rv", 32'(resp_valid), 0);
        chk("async_flags", 32'(flags), 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_flags = '0; m_rr = 0;
        @(negedge clk);

        for (int it = 0; it < 150; it++) begin
            int fm, rsel;
            logic [NUM_REQ-1:0] vm;
            for (int i = 0; i < NUM_REQ; i++) begin
                logic [4:0] opc;
                logic [15:0] b;
                opc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
                b   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                set_slot(i, opc, 16'($urandom), b, 4'($urandom_range(0, 15)));
            end
            vm   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            rsel = $urandom_range(0, 19);
            fm   = (rsel < 2) ? 1 : (rsel < 3) ? 2 : 0;
            do_op(vm, $urandom_range(0, 3), fm, r0, r1, wr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares the single combinational ALU between NUM_REQ requesters, e.g. the EX stage, the interrupt/exception handler and the debug port.
- Round-robin arbitrates requests and drives the ALU operand/opcode inputs from registered copies.
- Counts extra cycles for MUL/DIV, captures results, owns the architectural flag register and returns tagged responses over valid/ready.
- Replaces the standalone flag register: flags are committed only when an operation completes.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_W, 1, width of requester id; must equal clog2(NUM_REQ).
- MULDIV_LAT, 3, cycles spent in EXEC for `MUL/`DIV (>=1); all other opcodes spend 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; abandons the in-flight operation.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_opcode  in  NUM_REQ*5  flattened; slot i is [5i+4:5i].
- req_op1  in  NUM_REQ*16  flattened operand 1.
- req_op2  in  NUM_REQ*16  flattened operand 2.
- req_bitpos  in  NUM_REQ*4  flattened bit position.
- alu_opcode  out  5  to ALU.
- alu_operand_1  out  16  to ALU.
- alu_operand_2  out  16  to ALU.
- alu_bit_position  out  4  to ALU.
- alu_current_flags  out  16  flag register value, to ALU.
- alu_result_0  in  16  from ALU.
- alu_result_1  in  16  from ALU.
- alu_next_flags  in  16  from ALU.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts.
- resp_id  out  ID_W  requester index.
- resp_result_0  out  16  captured result_0.
- resp_result_1  out  16  captured result_1.
- resp_wr_en  out  2  register write enables: bit0 writes result_0, bit1 writes result_1.
- flags  out  16  architectural flags; same value as alu_current_flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE; rr_ptr = 0; flags = 0.
  - All captured opcode/operand/result registers = 0; resp_valid = 0; resp_wr_en = 0; resp_id = 0; cycle counter = 0.
  - Reset asserted mid-operation discards the operation and commits no flags.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: the first requester with req_valid=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is one-hot to the granted requester and is only ever asserted in IDLE.
  - On handshake: capture opcode, op1, op2, bitpos and id; rr_ptr <= (id+1) mod NUM_REQ; counter <= MULDIV_LAT-1 for `MUL/`DIV, else 0; go to EXEC.
  - With no request, the state is held and rr_ptr is unchanged.
- EXEC:
  - alu_* outputs driven from the captured registers; they are 0 outside EXEC.
  - If counter != 0: decrement the counter.
  - If counter == 0: capture alu_result_0/1 into resp_result_0/1, write alu_next_flags into flags, go to RESP.
- RESP:
  - resp_valid = 1; all resp_* outputs are held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE.
  - No new grant is issued in the same cycle; issue resumes in IDLE on the next cycle.
- Latency (handshake at edge 0):
  - Single-cycle ops: resp_valid high after edge 2.
  - MUL/DIV: resp_valid high after edge 1+MULDIV_LAT.
  - Sustained throughput: one op per 3 cycles at best.
- resp_wr_en:
  - 2'b11 for `MUL, and for `DIV with op2 != 0.
  - 2'b01 for `DIV with op2 == 0; result_0 = 16'hFFFF and V is set by the ALU.
  - 2'b00 for `CMP, `SETF, `CLRF, `CPLF (flags only).
  - 2'b01 for all other defined opcodes.
  - Undefined opcodes: 2'b00; flags are rewritten with alu_next_flags.
- Flag commit happens exactly once per operation, at the EXEC->RESP edge. A request accepted in IDLE sees flags that already include the previous op.
- flush:
  - In EXEC: go to IDLE with no flag commit and no response.
  - In RESP: go to IDLE and drop the response; flags are already committed.
  - In IDLE: no effect, and req_ready is forced to 0 that cycle.
  - flush has priority over resp_ready and over counter expiry.

Decomposition:
- Opcode macros come from parameters.v; add the RESP_WR_NONE/R0/R0R1 encodings there.
- The state encoding stays local to the module.
- One sub-module, rr_arbiter: parameterised NUM_REQ, combinational one-hot grant from req_valid and rr_ptr, reused by future bus arbitration.

Test Plan:
- Reset release, req0 `ADD 16'h7FFF+16'h0001 -> resp at cycle 2: id 0, result_0 16'h8000, wr_en 01; flags: V=1, N=1, C=0, Z=0, P=0 (16'h8000 has one set bit).
- Both requesters valid continuously with rr_ptr=0 -> grants alternate 0,1,0,1; each resp_id matches its grant order.
- `MUL 16'h1234*16'h0100, MULDIV_LAT=3 -> resp_valid after edge 4; result_1 16'h0012, result_0 16'h3400, wr_en 11.
- `DIV 16'h0010/16'h0000 -> result_0 16'hFFFF, wr_en 01, flags[1]=1; a following `SETF bitpos=4 -> wr_en 00, flags[4]=1, flags[1] still 1.
- resp_ready held low 5 cycles -> resp_* stable, req_ready stays 0; flush during MUL EXEC -> no resp, flags unchanged from the prior value.
- reset_n pulsed low mid-EXEC -> busy=0, resp_valid=0 and flags=0 immediately (asynchronous), before the next clock edge.
